po_capture_fifo: RTL

PO_CAPTURE_FIFO -- requirements
Module: po_capture_fifo

---
 rtl/po_capture_fifo_if.sv | 29 ++
 rtl/po_capture_fifo.sv | 82 ++++++++
 2 files changed

// File: rtl/po_capture_fifo_if.sv
// Bundle of capture-side and consumer-side signals for po_capture_fifo.
// The master modport is the producer/consumer environment; the FIFO is the slave.
interface po_capture_fifo_if #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_vec;
  logic             in_strobe;
  logic             chg_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             ovf_clr;
  logic [7:0]       drop_cnt;

  modport master (
    output in_vec, in_strobe, chg_en, out_ready, ovf_clr,
    input  out_valid, out_data, count, ovf, drop_cnt
  );

  modport slave (
    input  in_vec, in_strobe, chg_en, out_ready, ovf_clr,
    output out_valid, out_data, count, ovf, drop_cnt
  );
endinterface

// File: rtl/po_capture_fifo.sv
// Capture FIFO for an upstream result vector: pushes on strobe or on change,
// first-word fall-through read side, sticky overflow and saturating drop counter.
module po_capture_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  po_capture_fifo_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_vec_q;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic push_req, pop, full, push_ok, drop;

  // Read handshake: an entry transfers on a cycle where out_valid and out_ready
  // are both high; out_ready is ignored while out_valid is low.
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (count_q != '0) && bus.out_ready;
  assign push_req = bus.in_strobe || (bus.chg_en && (bus.in_vec != last_vec_q));
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_vec_q <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_vec_q <= bus.in_vec;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= bus.in_vec;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule
